// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry and stall counter
//
// Purpose:
//   Holds one writeback-bound entry (control bundle, ALU result, load data,
//   destination index) between two pipeline stages using a valid/ready
//   handshake. A bubble presents an all-zero control bundle so it can never
//   write the register file.
//
// Build option:
//   PIPE_SKID_EN - when defined, a second (skid) entry is added and in_ready
//                  becomes a register that does not depend on out_ready.
//                  When undefined, a single entry is held and in_ready is
//                  combinational (!out_valid || out_ready).
//
// Parameters:
//   DATA_W  - width of the ALU result and load data payloads
//   DST_W   - width of the destination register index
//   CTRL_W  - width of the control bundle (bit0 reg_write, bit1 mem_to_reg)
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   flush      - synchronous squash of all held entries (wins over transfers)
//   in_valid   - upstream entry present
//   in_ready   - stage accepts an entry this cycle
//   in_ctrl    - upstream control bundle
//   in_alu     - upstream ALU result
//   in_load    - upstream load data
//   in_dst     - upstream destination index
//   out_valid  - stage presents an entry
//   out_ready  - downstream accepts the presented entry
//   out_ctrl   - presented control bundle, zero while out_valid=0
//   out_alu    - presented ALU result
//   out_load   - presented load data
//   out_dst    - presented destination index
//   stall_cnt  - saturating count of cycles with out_valid=1 and out_ready=0

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 5,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_load,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_load,
    output logic [DST_W-1:0]  out_dst,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Main entry: the one presented on the outputs.
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_alu_q;
    logic [DATA_W-1:0] main_load_q;
    logic [DST_W-1:0]  main_dst_q;

    logic in_xfer;
    logic out_xfer;
    logic load_main_from_in;

    assign out_valid = (state_q != EMPTY);
    assign out_xfer  = out_valid && out_ready;
    assign in_xfer   = in_valid && in_ready;

    // Control is masked on bubbles; payloads simply keep their last values.
    assign out_ctrl = out_valid ? main_ctrl_q : '0;
    assign out_alu  = main_alu_q;
    assign out_load = main_load_q;
    assign out_dst  = main_dst_q;

`ifdef PIPE_SKID_EN

    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_alu_q;
    logic [DATA_W-1:0] skid_load_q;
    logic [DST_W-1:0]  skid_dst_q;
    logic              in_ready_q;
    logic              load_skid;
    logic              load_main_from_skid;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d             = state_q;
        load_main_from_in   = 1'b0;
        load_skid           = 1'b0;
        load_main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d           = ONE;
                        load_main_from_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_from_in = 1'b1;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new entry behind main.
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        state_d             = ONE;
                        load_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Registered ready breaks the out_ready -> in_ready path.
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl_q <= '0;
            skid_alu_q  <= '0;
            skid_load_q <= '0;
            skid_dst_q  <= '0;
        end else if (load_skid) begin
            skid_ctrl_q <= in_ctrl;
            skid_alu_q  <= in_alu;
            skid_load_q <= in_load;
            skid_dst_q  <= in_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= '0;
            main_alu_q  <= '0;
            main_load_q <= '0;
            main_dst_q  <= '0;
        end else if (load_main_from_in) begin
            main_ctrl_q <= in_ctrl;
            main_alu_q  <= in_alu;
            main_load_q <= in_load;
            main_dst_q  <= in_dst;
        end else if (load_main_from_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_alu_q  <= skid_alu_q;
            main_load_q <= skid_load_q;
            main_dst_q  <= skid_dst_q;
        end
    end

`else

    // Single entry: accept when empty or when the held entry leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        state_d           = state_q;
        load_main_from_in = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (in_xfer) begin
            state_d           = ONE;
            load_main_from_in = 1'b1;
        end else if (out_xfer) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= '0;
            main_alu_q  <= '0;
            main_load_q <= '0;
            main_dst_q  <= '0;
        end else if (load_main_from_in) begin
            main_ctrl_q <= in_ctrl;
            main_alu_q  <= in_alu;
            main_load_q <= in_load;
            main_dst_q  <= in_dst;
        end
    end

`endif

    // Counts stalled cycles independently of flush; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_alu;
    logic [31:0] in_load;
    logic [4:0]  in_dst;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [31:0] out_alu;
    logic [31:0] out_load;
    logic [4:0]  out_dst;
    logic [15:0] stall_cnt;

    int vectors;
    int miscompares;

    pipe_stage_reg #(
        .DATA_W(32),
        .DST_W (5),
        .CTRL_W(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_alu   (in_alu),
        .in_load  (in_load),
        .in_dst   (in_dst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_alu  (out_alu),
        .out_load (out_load),
        .out_dst  (out_dst),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = 2'b00;
        in_alu = 32'h0; in_load = 32'h0; in_dst = 5'd0; out_ready = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        vectors++; if (out_ctrl !== 2'b00) begin miscompares++; $display("FAIL reset_out_ctrl got %b exp 00", out_ctrl); end
        vectors++; if (out_alu !== 32'h0 || out_load !== 32'h0 || out_dst !== 5'd0) begin miscompares++; $display("FAIL reset_payload got %h/%h/%h exp 0/0/0", out_alu, out_load, out_dst); end
        vectors++; if (stall_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_stall_cnt got %h exp 0000", stall_cnt); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_alu = 32'h0000_0001; in_load = 32'h0000_00A5;
        in_dst = 5'd1; in_ctrl = 2'b11; out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        vectors++; if (out_alu !== 32'h1 || out_dst !== 5'd1 || out_load !== 32'hA5) begin miscompares++; $display("FAIL single_payload got %h/%h/%h exp 1/1/a5", out_alu, out_dst, out_load); end
        vectors++; if (out_ctrl !== 2'b11) begin miscompares++; $display("FAIL single_out_ctrl got %b exp 11", out_ctrl); end
        step();
        vectors++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00) begin miscompares++; $display("FAIL bubble_ctrl got v=%b c=%b exp v=0 c=00", out_valid, out_ctrl); end
        vectors++; if (out_alu !== 32'h1 || out_dst !== 5'd1) begin miscompares++; $display("FAIL bubble_hold got %h/%h exp 1/1", out_alu, out_dst); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_alu = 32'(i); in_load = 32'(i + 100);
            in_dst = 5'(i); in_ctrl = 2'b01;
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            step();
            vectors++; if (out_valid !== 1'b1 || out_alu !== 32'(i) || out_dst !== 5'(i)) begin miscompares++; $display("FAIL b2b_out[%0d] got v=%b alu=%0d dst=%0d exp v=1 alu=%0d dst=%0d", i, out_valid, out_alu, out_dst, i, i); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL b2b_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_stall();
        logic exp_ready_b;
`ifdef PIPE_SKID_EN
        exp_ready_b = 1'b1;
`else
        exp_ready_b = 1'b0;
`endif
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu = 32'd10; in_dst = 5'd10; in_ctrl = 2'b01;
        step();
        vectors++; if (out_valid !== 1'b1 || out_alu !== 32'd10) begin miscompares++; $display("FAIL stall_first got v=%b alu=%0d exp v=1 alu=10", out_valid, out_alu); end
        in_alu = 32'd11; in_dst = 5'd11;
        #1;
        vectors++; if (in_ready !== exp_ready_b) begin miscompares++; $display("FAIL stall_second_ready got %b exp %b", in_ready, exp_ready_b); end
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_full_ready got %b exp 0", in_ready); end
        vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL stall_cnt_1 got %0d exp 1", stall_cnt); end
        step();
        vectors++; if (out_alu !== 32'd10 || out_dst !== 5'd10 || out_ctrl !== 2'b01) begin miscompares++; $display("FAIL stall_hold got %0d/%0d/%b exp 10/10/01", out_alu, out_dst, out_ctrl); end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_alu !== 32'd11 || out_dst !== 5'd11) begin miscompares++; $display("FAIL stall_release got v=%b alu=%0d exp v=1 alu=11", out_valid, out_alu); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_empty got %b exp 0", out_valid); end
        vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL stall_cnt_2 got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu = 32'd20; in_dst = 5'd20; in_ctrl = 2'b11;
        step();
        in_alu = 32'd21; in_dst = 5'd21;
        step();
        flush = 1'b1; in_alu = 32'd22; in_dst = 5'd22;
        step();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00) begin miscompares++; $display("FAIL flush_out got v=%b c=%b exp v=0 c=00", out_valid, out_ctrl); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        vectors++; if (out_alu !== 32'd20) begin miscompares++; $display("FAIL flush_hold_alu got %0d exp 20", out_alu); end
        vectors++; if (stall_cnt !== 16'd4) begin miscompares++; $display("FAIL flush_stall_cnt got %0d exp 4", stall_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ghost[%0d] got v=%b alu=%0d exp v=0", k, out_valid, out_alu); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu = 32'd30; in_dst = 5'd30; in_ctrl = 2'b01;
        step();
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b1 || stall_cnt !== 16'd5) begin miscompares++; $display("FAIL pre_reset got v=%b cnt=%0d exp v=1 cnt=5", out_valid, stall_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin miscompares++; $display("FAIL async_reset got v=%b cnt=%0d exp v=0 cnt=0", out_valid, stall_cnt); end
        vectors++; if (in_ready !== 1'b1 || out_alu !== 32'd0 || out_ctrl !== 2'b00) begin miscompares++; $display("FAIL async_reset_out got rdy=%b alu=%0d c=%b exp 1/0/00", in_ready, out_alu, out_ctrl); end
        in_valid = 1'b1; in_alu = 32'd31;
        step();
        vectors++; if (out_valid !== 1'b0 || out_alu !== 32'd0) begin miscompares++; $display("FAIL reset_no_accept got v=%b alu=%0d exp v=0 alu=0", out_valid, out_alu); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset got %b exp 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu = 32'd40; in_dst = 5'd4; in_ctrl = 2'b01;
        step();
        in_valid = 1'b0;
        repeat (65534) step();
        vectors++; if (stall_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_fffe got %h exp fffe", stall_cnt); end
        step();
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_ffff got %h exp ffff", stall_cnt); end
        repeat (5) step();
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_nowrap got %h exp ffff", stall_cnt); end
        vectors++; if (out_valid !== 1'b1 || out_alu !== 32'd40) begin miscompares++; $display("FAIL sat_hold got v=%b alu=%0d exp v=1 alu=40", out_valid, out_alu); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0 || stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_drain got v=%b cnt=%h exp v=0 cnt=ffff", out_valid, stall_cnt); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- DATA_W, 32: width of the ALU result and load data payloads.
- DST_W, 5: width of the destination register index.
- CTRL_W, 2: width of the control bundle; bit0 is reg_write, bit1 is mem_to_reg.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous squash of all held entries.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: the stage accepts an entry this cycle.
- in_ctrl, in, CTRL_W: upstream control bits.
- in_alu, in, DATA_W: upstream ALU result.
- in_load, in, DATA_W: upstream load data.
- in_dst, in, DST_W: upstream destination index.
- out_valid, out, 1: the stage presents an entry.
- out_ready, in, 1: downstream accepts the presented entry.
- out_ctrl, out, CTRL_W: presented control bits.
- out_alu, out, DATA_W: presented ALU result.
- out_load, out, DATA_W: presented load data.
- out_dst, out, DST_W: presented destination index.
- stall_cnt, out, 16: saturating count of cycles in which out_valid=1 and out_ready=0.

Function
REQ-004 An input transfer SHALL occur when in_valid=1 and in_ready=1 at a rising edge; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-005 An accepted entry SHALL appear on the outputs with out_valid=1 on the cycle after acceptance, giving a latency of 1 cycle when the stage is empty.
REQ-006 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-007 While out_valid=1 and out_ready=0, all out_* payloads SHALL be held stable.
REQ-008 out_ctrl SHALL be all-zero whenever out_valid=0, so that a bubble never writes the register file; out_alu, out_load and out_dst SHALL hold their last values in that case.
REQ-009 flush=1 SHALL clear every entry at the edge, discarding any input transfer in the same cycle; out_valid SHALL be 0 on the next cycle.
REQ-010 flush SHALL take priority over any simultaneous input or output transfer.
REQ-011 stall_cnt SHALL increment by 1 on each cycle in which out_valid=1 and out_ready=0, and SHALL saturate at 16'hFFFF.
REQ-012 stall_cnt SHALL be unaffected by flush.
REQ-013 A simultaneous input transfer and output transfer SHALL keep the occupancy unchanged and SHALL be sustainable at full throughput, one entry per cycle.

Reset
REQ-014 While rst_n=0, the block SHALL force out_valid=0, out_ctrl=0, out_alu=0, out_load=0, out_dst=0, stall_cnt=0, state EMPTY and in_ready=1, without waiting for a clock edge.
REQ-015 An assertion of rst_n mid-transfer SHALL discard all held entries; no input transfer SHALL be recorded while rst_n=0.

Configuration
REQ-016 With PIPE_SKID_EN defined, the block SHALL hold 2 entries (main and skid) using the states EMPTY, ONE and FULL:
- in_ready SHALL be a register equal to (state != FULL), with no combinational path from out_ready.
- An accept while stalled in ONE SHALL go to FULL.
- An output transfer in FULL SHALL promote the skid entry to main and go to ONE.

REQ-017 Without PIPE_SKID_EN, the block SHALL hold one entry:
- in_ready SHALL equal (!out_valid || out_ready) combinationally.
- There SHALL be no skid storage.

Verification
REQ-018 Reset, then in_valid=1 with in_alu=32'h0000_0001, in_dst=5'd1, in_ctrl=2'b11, out_ready=1 -> on the next cycle out_valid=1, out_alu=1, out_dst=1, out_ctrl=2'b11.
REQ-019 Streaming of 8 back-to-back entries (values 1..8) with out_ready=1 -> outputs 1..8 in order on consecutive cycles, stall_cnt=0.
REQ-020 With PIPE_SKID_EN, out_ready=0 while 2 entries are offered -> in_ready=0 after the second accept; releasing out_ready yields both entries in order, and stall_cnt equals the number of stall cycles.
REQ-021 flush=1 with the stage FULL and in_valid=1 -> out_valid=0 and out_ctrl=0 on the next cycle, and the flushed and concurrent entries never appear.
REQ-022 rst_n pulled low asynchronously between edges while out_valid=1 -> out_valid=0 and stall_cnt=0 immediately.
REQ-023 out_ready=0 held for 70000 cycles with out_valid=1 -> stall_cnt=16'hFFFF with no wrap.
